avmm_burst_responder: RTL and testbench

AVMM_BURST_RESPONDER -- requirements
Module: avmm_burst_responder

---
 rtl/avmm_responder_pkg.sv | 19 +
 rtl/avmm_responder_ram.sv | 48 ++++
 rtl/avmm_burst_responder.sv | 187 ++++++++++++++++++
 tb/tb_avmm_burst_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_responder_pkg.sv
// Shared types and constants for the Avalon-MM burst responder.
//   state_t          : responder FSM states
//   READ_LATENCY_MIN : smallest supported read latency (cycles)
//   READ_LATENCY_MAX : largest supported read latency (cycles)
//   WAIT_CNT_WIDTH   : width of the read-latency wait counter
package avmm_responder_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        READ_DATA = 2'd3
    } state_t;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 15;
    localparam int unsigned WAIT_CNT_WIDTH   = 4;

endpackage

// File: rtl/avmm_responder_ram.sv
// Byte-enabled single-port RAM, DATA_WIDTH x 2**ADDR_BITS, registered read.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears rdata only;
//                  the storage array is never cleared)
//   we, be, wdata: write strobe, byte lane enables, write data
//   re           : read strobe; rdata updates one cycle later
//   addr         : word address shared by read and write
//   rdata        : registered read data
module avmm_responder_ram #(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned BYTEENABLE_WIDTH = 8,
    parameter int unsigned ADDR_BITS        = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        we,
    input  logic                        re,
    input  logic [ADDR_BITS-1:0]        addr,
    input  logic [BYTEENABLE_WIDTH-1:0] be,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Lane-gated write; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < BYTEENABLE_WIDTH; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst slave backed by an internal byte-enabled RAM.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   address        : word address; only the low MEM_ADDR_BITS are used
//   burstcount     : beats per command (0 is treated as 1)
//   read, write    : command strobes (read wins when both are high in IDLE)
//   writedata, byteenable : write beat payload and lane enables
//   waitrequest    : high while a read burst is in flight (and on stall cycles)
//   readdata, readdatavalid : read beats, first one READ_LATENCY cycles after accept
// Optional feature: define AVMM_RESPONDER_STALL_EN to insert a one-cycle
// waitrequest every 16 cycles while in IDLE/WRITE.
module avmm_burst_responder
    import avmm_responder_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = 29,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned BURSTCOUNT_WIDTH = 8,
    parameter int unsigned BYTEENABLE_WIDTH = 8,
    parameter int unsigned MEM_ADDR_BITS    = 10,
    parameter int unsigned READ_LATENCY     = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        waitrequest,
    input  logic [BURSTCOUNT_WIDTH-1:0] burstcount,
    input  logic [ADDRESS_WIDTH-1:0]    address,
    output logic [DATA_WIDTH-1:0]       readdata,
    output logic                        readdatavalid,
    input  logic                        read,
    input  logic [DATA_WIDTH-1:0]       writedata,
    input  logic [BYTEENABLE_WIDTH-1:0] byteenable,
    input  logic                        write
);

    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
        $error("READ_LATENCY out of range");
    end

    state_t                      state, state_next;
    logic [MEM_ADDR_BITS-1:0]    base_q, base_d;
    logic [BURSTCOUNT_WIDTH-1:0] len_q, len_d;
    logic [BURSTCOUNT_WIDTH-1:0] beat_q, beat_d;
    logic [WAIT_CNT_WIDTH-1:0]   wait_q, wait_d;
    logic                        ram_we_c, ram_re_c;
    logic [MEM_ADDR_BITS-1:0]    ram_addr_c;
    logic                        waitreq_next_c;
    logic                        stall_c, stall_next_c;
    logic                        unused_addr_hi;

    // Upper address bits are deliberately ignored.
    assign unused_addr_hi = ^address[ADDRESS_WIDTH-1:MEM_ADDR_BITS];

    function automatic logic [BURSTCOUNT_WIDTH-1:0] eff_len(input logic [BURSTCOUNT_WIDTH-1:0] bc);
        return (bc == '0) ? BURSTCOUNT_WIDTH'(1) : bc;
    endfunction

`ifdef AVMM_RESPONDER_STALL_EN
    logic [3:0] stall_q;

    // Free-running stall timer; stall_next_c lets waitrequest be registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= 4'h0;
        end else begin
            stall_q <= stall_q + 4'h1;
        end
    end

    assign stall_c      = (stall_q == 4'hF);
    assign stall_next_c = (stall_q == 4'hE);
`else
    assign stall_c      = 1'b0;
    assign stall_next_c = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            wait_q        <= '0;
            waitrequest   <= 1'b1;
            readdatavalid <= 1'b0;
        end else begin
            state         <= state_next;
            base_q        <= base_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            wait_q        <= wait_d;
            waitrequest   <= waitreq_next_c;
            readdatavalid <= ram_re_c;
        end
    end

    // Next-state, counters and RAM control.
    always_comb begin
        state_next = state;
        base_d     = base_q;
        len_d      = len_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        ram_we_c   = 1'b0;
        ram_re_c   = 1'b0;
        ram_addr_c = base_q + MEM_ADDR_BITS'(beat_q);

        case (state)
            IDLE: begin
                beat_d = '0;
                wait_d = '0;
                if (!stall_c) begin
                    if (read) begin
                        base_d     = address[MEM_ADDR_BITS-1:0];
                        len_d      = eff_len(burstcount);
                        state_next = (READ_LATENCY == 1) ? READ_DATA : READ_WAIT;
                    end else if (write) begin
                        // First beat is stored straight from the command.
                        base_d     = address[MEM_ADDR_BITS-1:0];
                        len_d      = eff_len(burstcount);
                        ram_addr_c = address[MEM_ADDR_BITS-1:0];
                        ram_we_c   = 1'b1;
                        if (eff_len(burstcount) != BURSTCOUNT_WIDTH'(1)) begin
                            state_next = WRITE;
                            beat_d     = BURSTCOUNT_WIDTH'(1);
                        end
                    end
                end
            end
            WRITE: begin
                if (write && !stall_c) begin
                    ram_we_c = 1'b1;
                    if (beat_q == len_q - BURSTCOUNT_WIDTH'(1)) begin
                        state_next = IDLE;
                        beat_d     = '0;
                    end else begin
                        beat_d = beat_q + BURSTCOUNT_WIDTH'(1);
                    end
                end
            end
            READ_WAIT: begin
                // READ_DATA issues the RAM read one cycle before the beat appears.
                if (wait_q == WAIT_CNT_WIDTH'(READ_LATENCY - 2)) begin
                    state_next = READ_DATA;
                    wait_d     = '0;
                end else begin
                    wait_d = wait_q + WAIT_CNT_WIDTH'(1);
                end
            end
            READ_DATA: begin
                ram_re_c = 1'b1;
                if (beat_q == len_q - BURSTCOUNT_WIDTH'(1)) begin
                    state_next = IDLE;
                    beat_d     = '0;
                end else begin
                    beat_d = beat_q + BURSTCOUNT_WIDTH'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A burst interrupted by reset must not touch memory.
        if (!reset_n) begin
            ram_we_c = 1'b0;
        end

        waitreq_next_c = (state_next == READ_WAIT) || (state_next == READ_DATA) || stall_next_c;
    end

    avmm_responder_ram #(
        .DATA_WIDTH       (DATA_WIDTH),
        .BYTEENABLE_WIDTH (BYTEENABLE_WIDTH),
        .ADDR_BITS        (MEM_ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (ram_we_c),
        .re      (ram_re_c),
        .addr    (ram_addr_c),
        .be      (byteenable),
        .wdata   (writedata),
        .rdata   (readdata)
    );

endmodule

// File: tb/tb_avmm_burst_responder.sv
// Directed bench for avmm_burst_responder with a read-data scoreboard.
module tb_avmm_burst_responder;

    localparam int unsigned AW = 29;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 8;
    localparam int unsigned EW = 8;
    localparam int unsigned MB = 10;
    localparam int unsigned L  = 3;

    typedef struct {
        logic [63:0] data;
        int unsigned cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          waitrequest;
    logic [BW-1:0] burstcount = '0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          read = 1'b0;
    logic [DW-1:0] writedata = '0;
    logic [EW-1:0] byteenable = '0;
    logic          write = 1'b0;

    int unsigned   n_cmp = 0;
    int unsigned   n_fail = 0;
    int unsigned   pcnt = 0;
    int unsigned   stalls_seen = 0;
    exp_t          sb_q[$];
    logic [63:0]   model [1024];

    avmm_burst_responder #(
        .ADDRESS_WIDTH    (AW),
        .DATA_WIDTH       (DW),
        .BURSTCOUNT_WIDTH (BW),
        .BYTEENABLE_WIDTH (EW),
        .MEM_ADDR_BITS    (MB),
        .READ_LATENCY     (L)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .waitrequest   (waitrequest),
        .burstcount    (burstcount),
        .address       (address),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .read          (read),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .write         (write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Read-beat monitor: every valid beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (readdatavalid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rdv", 64'(readdatavalid), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("read_data", readdata, e.data);
                check("rdv_cycle", 64'(pcnt), 64'(e.cyc));
            end
        end
    end

    task automatic write_burst(input int unsigned addr, input int unsigned n,
                               input logic [63:0] first, input logic [7:0] be, input bit gap);
        int unsigned i = 0;
        int unsigned cyc = 0;
        bit gapped = 1'b0;
        bit stalled;
        logic [63:0] d;
        int unsigned idx;
        while (i < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            d          = first + 64'(i);
            read       = 1'b0;
            address    = AW'(addr);
            burstcount = BW'(n);
            byteenable = be;
            writedata  = d;
            if (gap && i == 2 && !gapped) begin
                write   = 1'b0;
                gapped  = 1'b1;
                stalled = 1'b1;
            end else begin
                write   = 1'b1;
                stalled = waitrequest;
                if (stalled) stalls_seen++;
            end
            @(posedge clk);
            if (!stalled) begin
                idx = (addr + i) % 1024;
                for (int b = 0; b < 8; b++) begin
                    if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
                end
                i++;
            end
        end
        #1 write = 1'b0;
        check("write_beats", 64'(i), 64'(n));
    endtask

    // Issue a read and queue n_exp expected beats (0 = the whole burst).
    task automatic read_issue(input int unsigned addr, input int unsigned bc,
                              input bit with_write, input int unsigned n_exp);
        int unsigned n;
        int unsigned c0 = 0;
        int unsigned cyc = 0;
        bit accepted = 1'b0;
        n = (bc == 0) ? 1 : bc;
        if (n_exp != 0) n = n_exp;
        while (!accepted && cyc < 100) begin
            @(negedge clk);
            cyc++;
            read       = 1'b1;
            write      = with_write;
            writedata  = 64'hDEAD_BEEF_DEAD_BEEF;
            byteenable = 8'hFF;
            address    = AW'(addr);
            burstcount = BW'(bc);
            if (!waitrequest) begin
                accepted = 1'b1;
                c0       = pcnt;
            end
        end
        check("read_accept", 64'(accepted), 64'(1));
        if (accepted) begin
            for (int unsigned i = 0; i < n; i++) begin
                sb_q.push_back('{model[(addr + i) % 1024], c0 + 1 + L + i});
            end
            @(posedge clk);
        end
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic drain();
        int unsigned cyc = 0;
        while (sb_q.size() != 0 && cyc < 600) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("drain", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) model[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 64'(waitrequest), 64'(1));
        check("rst_rdv", 64'(readdatavalid), 64'(0));
        check("rst_readdata", readdata, 64'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_waitrequest", 64'(waitrequest), 64'(0));

        // Basic burst write/read.
        write_burst(32'h10, 4, 64'd1, 8'hFF, 1'b0);
        read_issue(32'h10, 4, 1'b0, 0);
        drain();

        // Byte-lane gating.
        write_burst(32'h20, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        write_burst(32'h20, 1, 64'h0, 8'h0F, 1'b0);
        read_issue(32'h20, 1, 1'b0, 0);
        drain();

        // Address wrap at the top of memory.
        write_burst(32'h3FF, 2, 64'hAAAA_5555_0000_1000, 8'hFF, 1'b0);
        read_issue(32'h3FF, 1, 1'b0, 0);
        drain();
        read_issue(32'h000, 1, 1'b0, 0);
        drain();
        read_issue(32'h3FF, 2, 1'b0, 0);
        drain();

        // burstcount 0 behaves as 1; upper address bits ignored.
        read_issue(32'h10, 0, 1'b0, 0);
        drain();
        read_issue(32'h0010_0010, 1, 1'b0, 0);
        drain();

        // Read beats write when both asserted; memory untouched.
        read_issue(32'h10, 1, 1'b1, 0);
        drain();
        read_issue(32'h10, 1, 1'b0, 0);
        drain();

        // Idle beat inside a write burst.
        write_burst(32'h50, 5, 64'h500, 8'hFF, 1'b1);
        read_issue(32'h50, 5, 1'b0, 0);
        drain();

        // Write immediately followed by read of the same address.
        write_burst(32'h60, 1, 64'h6666_7777_8888_9999, 8'hFF, 1'b0);
        read_issue(32'h60, 1, 1'b0, 0);
        drain();

        // Maximum burst length.
        write_burst(32'h100, 255, 64'h1000, 8'hFF, 1'b0);
        read_issue(32'h100, 255, 1'b0, 0);
        drain();

        // 32-beat write with write held high.
        stalls_seen = 0;
        write_burst(32'h200, 32, 64'h2000, 8'hFF, 1'b0);
`ifdef AVMM_RESPONDER_STALL_EN
        check("stall_pulses", 64'(stalls_seen != 0), 64'(1));
`else
        check("no_stall", 64'(stalls_seen), 64'(0));
`endif
        read_issue(32'h200, 32, 1'b0, 0);
        drain();

        // Reset during a read burst, after three beats.
        write_burst(32'h10, 8, 64'd1, 8'hFF, 1'b0);
        read_issue(32'h10, 8, 1'b0, 3);
        drain();
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_rdv", 64'(readdatavalid), 64'(0));
            check("midrst_waitrequest", 64'(waitrequest), 64'(1));
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("post_midrst_waitrequest", 64'(waitrequest), 64'(0));
        read_issue(32'h10, 1, 1'b0, 0);
        drain();

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
